// File: rtl/vga_pkg.sv
// Shared VGA constants, the pixel colour type and the sprite palette.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Pixel colour, packed {b,g,r}, 4 bits each.
  typedef logic [11:0] rgb_t;

  // Colour of sprite i; index 0 is also the highest-priority sprite.
  localparam rgb_t BALL_PALETTE [8] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
    12'hF0F, 12'h0FF, 12'hFFF, 12'h888
  };

endpackage

// File: rtl/sprite_mover.sv
// One sprite's position/direction state and its per-frame reflection step.
// Each axis moves by speed, clamps to [0, L] and turns around on a wall hit.
module sprite_mover
  import vga_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int BALL_SIZE = 4,
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int INIT_X    = 32,
  parameter int INIT_Y    = 32,
  parameter bit INIT_DX   = 1'b0,
  parameter bit INIT_DY   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic [2:0]         speed,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               flip
);

  // One extra bit so that pos - speed below zero is representable.
  typedef logic signed [COORD_W:0] scoord_t;

  typedef struct packed {
    logic               hit;
    logic               dir;
    logic [COORD_W-1:0] pos;
  } axis_t;

  localparam scoord_t LIM_X = scoord_t'(H_ACTIVE - BALL_SIZE);
  localparam scoord_t LIM_Y = scoord_t'(V_ACTIVE - BALL_SIZE);

  // dir = 1 means moving towards zero.
  function automatic axis_t move_axis(input logic [COORD_W-1:0] pos,
                                      input logic dir,
                                      input logic [2:0] spd,
                                      input scoord_t lim);
    scoord_t cur, dlt, nxt;
    axis_t   r;
    cur = scoord_t'({1'b0, pos});
    dlt = scoord_t'({{(COORD_W-2){1'b0}}, spd});
    nxt = dir ? cur - dlt : cur + dlt;
    r.hit = 1'b0;
    r.dir = dir;
    r.pos = nxt[COORD_W-1:0];
    if (nxt < 0) begin
      r.hit = 1'b1;
      r.dir = 1'b0;
      r.pos = '0;
    end else if (nxt > lim) begin
      r.hit = 1'b1;
      r.dir = 1'b1;
      r.pos = lim[COORD_W-1:0];
    end
    return r;
  endfunction

  logic  dir_x, dir_y;
  axis_t ax, ay;

  // Candidate next state for both axes, used only when step is high.
  always_comb begin
    ax = move_axis(pos_x, dir_x, speed, LIM_X);
    ay = move_axis(pos_y, dir_y, speed, LIM_Y);
  end

  assign flip = step & (ax.hit | ay.hit);

  // Sprite state: load the start position on reset, advance once per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x <= COORD_W'(INIT_X);
      pos_y <= COORD_W'(INIT_Y);
      dir_x <= INIT_DX;
      dir_y <= INIT_DY;
    end else if (step) begin
      pos_x <= ax.pos;
      pos_y <= ay.pos;
      dir_x <= ax.dir;
      dir_y <= ay.dir;
    end
  end

endmodule

// File: rtl/bounce_sprite_engine.sv
// Multi-ball bouncing sprite renderer fed by vga_sync coordinates.
// Sprites advance on the vsync rising edge (during blanking, so no tearing);
// the pixel colour is registered with one clock of latency.
// Build option: define BOUNCE_GRID_EN for a green dot grid background.
module bounce_sprite_engine
  import vga_pkg::*;
#(
  parameter int N_BALLS   = 4,
  parameter int BALL_SIZE = 4,
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int COORD_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic               vsync,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [2:0]         speed,
  input  logic               pause,
  output logic               bounce,
  output logic [11:0]        rgb
);

  logic                             vsync_q;
  logic                             frame_tick;
  logic                             step;
  logic [N_BALLS-1:0][COORD_W-1:0]  pos_x, pos_y;
  logic [N_BALLS-1:0]               flip;
  logic [N_BALLS-1:0]               hit;
  logic [N_BALLS:0][11:0]           chain;
  rgb_t                             bg;

  // vsync delay for rising-edge detection in the clk domain.
  always_ff @(posedge clk) begin
    if (reset) vsync_q <= 1'b0;
    else       vsync_q <= vsync;
  end

  assign frame_tick = vsync & ~vsync_q;
  assign step       = frame_tick & ~pause;

`ifdef BOUNCE_GRID_EN
  assign bg = (x[2:0] == 3'd0 && y[2:0] == 3'd0) ? rgb_t'(12'h0F0) : rgb_t'(12'h000);
`else
  assign bg = '0;
`endif

  // Priority chain: sprite 0 is evaluated last, so it wins any overlap.
  assign chain[N_BALLS] = bg;

  for (genvar g = 0; g < N_BALLS; g++) begin : g_ball
    logic [COORD_W-1:0] dx, dy;

    sprite_mover #(
      .COORD_W  (COORD_W),
      .BALL_SIZE(BALL_SIZE),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .INIT_X   (32 + 48 * g),
      .INIT_Y   (32 + 32 * g),
      .INIT_DX  (1'(g % 2)),
      .INIT_DY  (1'((g / 2) % 2))
    ) u_mover (
      .clk  (clk),
      .reset(reset),
      .step (step),
      .speed(speed),
      .pos_x(pos_x[g]),
      .pos_y(pos_y[g]),
      .flip (flip[g])
    );

    // Wrapping subtract: pixels left of / above the sprite become large.
    assign dx       = x - pos_x[g];
    assign dy       = y - pos_y[g];
    assign hit[g]   = (dx < COORD_W'(BALL_SIZE)) && (dy < COORD_W'(BALL_SIZE));
    assign chain[g] = hit[g] ? BALL_PALETTE[g] : chain[g+1];
  end

  // Reflection pulse, one cycle after the frame tick that caused it.
  always_ff @(posedge clk) begin
    if (reset) bounce <= 1'b0;
    else       bounce <= |flip;
  end

  // Output colour register; blanked outside the visible area.
  always_ff @(posedge clk) begin
    if (reset)         rgb <= '0;
    else if (video_on) rgb <= chain[0];
    else               rgb <= '0;
  end

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Self-checking bench for bounce_sprite_engine: table of pixel vectors at the
// reset positions, directed multi-cycle sequences, and a long motion run
// checked against a behavioural sprite model through a pixel scoreboard.
module tb_bounce_sprite_engine;

  localparam int N  = 8;
  localparam int BS = 4;
  localparam int CW = 10;
  localparam int H  = 640;
  localparam int V  = 480;
`ifdef BOUNCE_GRID_EN
  localparam logic [11:0] GRIDEXP = 12'h0F0;
`else
  localparam logic [11:0] GRIDEXP = 12'h000;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          video_on = 1'b0;
  logic          vsync = 1'b0;
  logic          pause = 1'b0;
  logic [CW-1:0] x = '0;
  logic [CW-1:0] y = '0;
  logic [2:0]    speed = '0;
  logic          bounce;
  logic [11:0]   rgb;

  int checks = 0;
  int errors = 0;

  bounce_sprite_engine #(
    .N_BALLS(N), .BALL_SIZE(BS), .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .vsync(vsync),
    .x(x), .y(y), .speed(speed), .pause(pause), .bounce(bounce), .rgb(rgb)
  );

  always #5 clk = ~clk;

  logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                           12'hF0F, 12'h0FF, 12'hFFF, 12'h888};

  // Behavioural sprite model.
  int mx [N];
  int my [N];
  bit mdx [N];
  bit mdy [N];

  typedef struct { string nm; logic [11:0] exp; } pend_t;
  typedef struct { int px; int py; bit von; logic [11:0] exp; string nm; } vec_t;
  pend_t expq[$];

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = 32 + 48 * i;
      my[i]  = 32 + 32 * i;
      mdx[i] = (i % 2) == 1;
      mdy[i] = ((i / 2) % 2) == 1;
    end
  endfunction

  function automatic void axis(inout int p, inout bit d, input int s, input int lim, inout bit h);
    int n;
    n = d ? p - s : p + s;
    if (n < 0) begin
      p = 0; d = 1'b0; h = 1'b1;
    end else if (n > lim) begin
      p = lim; d = 1'b1; h = 1'b1;
    end else begin
      p = n;
    end
  endfunction

  function automatic bit model_step(input int s);
    bit h;
    int p;
    bit d;
    h = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = mx[i]; d = mdx[i]; axis(p, d, s, H - BS, h); mx[i] = p; mdx[i] = d;
      p = my[i]; d = mdy[i]; axis(p, d, s, V - BS, h); my[i] = p; mdy[i] = d;
    end
    return h;
  endfunction

  function automatic logic [11:0] model_pix(input int px, input int py, input bit von);
    if (!von) return 12'h000;
    for (int i = 0; i < N; i++)
      if (((px - mx[i]) & 1023) < BS && ((py - my[i]) & 1023) < BS) return pal[i];
    if ((px % 8) == 0 && (py % 8) == 0) return GRIDEXP;
    return 12'h000;
  endfunction

  // Advance to the next falling edge and retire the oldest pending pixel.
  task automatic tick_edge();
    pend_t e;
    @(negedge clk);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check(e.nm, rgb, e.exp);
    end
  endtask

  task automatic pix_exp(input int px, input int py, input bit von,
                         input logic [11:0] exp, input string nm);
    pend_t e;
    int    wx, wy;
    tick_edge();
    wx = px; wy = py;
    x = wx[CW-1:0];
    y = wy[CW-1:0];
    video_on = von;
    e.nm = nm; e.exp = exp;
    expq.push_back(e);
  endtask

  task automatic pix(input int px, input int py, input bit von, input string nm);
    pix_exp(px & 1023, py & 1023, von, model_pix(px & 1023, py & 1023, von), nm);
  endtask

  // One vsync rise held for two clocks; checks the bounce pulse and its width.
  task automatic frame(input int spd, input bit pz);
    bit eb;
    tick_edge();
    speed = 3'(spd);
    pause = pz;
    vsync = 1'b1;
    eb = pz ? 1'b0 : model_step(spd);
    @(negedge clk);
    check("bounce", {11'b0, bounce}, {11'b0, eb});
    @(negedge clk);
    check("bounce_pulse", {11'b0, bounce}, 12'h000);
    vsync = 1'b0;
  endtask

  // Probe every sprite around its corner (offsets -1..4 also hit the edges).
  task automatic probe_all(input bit rnd);
    int ox, oy;
    bit von;
    for (int i = 0; i < N; i++) begin
      ox  = rnd ? int'($urandom_range(5, 0)) - 1 : 0;
      oy  = rnd ? int'($urandom_range(5, 0)) - 1 : 0;
      von = rnd ? ($urandom_range(7, 0) != 0) : 1'b1;
      pix(mx[i] + ox, my[i] + oy, von, "sprite_pix");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [14];
    tbl[0]  = '{32,  32,  1'b1, 12'hF00, "init_s0_tl"};
    tbl[1]  = '{35,  35,  1'b1, 12'hF00, "init_s0_br"};
    tbl[2]  = '{36,  32,  1'b1, 12'h000, "init_s0_right_out"};
    tbl[3]  = '{31,  35,  1'b1, 12'h000, "init_s0_left_wrap"};
    tbl[4]  = '{80,  64,  1'b1, 12'h0F0, "init_s1"};
    tbl[5]  = '{83,  67,  1'b1, 12'h0F0, "init_s1_br"};
    tbl[6]  = '{128, 96,  1'b1, 12'h00F, "init_s2"};
    tbl[7]  = '{176, 128, 1'b1, 12'hFF0, "init_s3_over_grid"};
    tbl[8]  = '{224, 160, 1'b1, 12'hF0F, "init_s4"};
    tbl[9]  = '{272, 192, 1'b1, 12'h0FF, "init_s5"};
    tbl[10] = '{320, 224, 1'b1, 12'hFFF, "init_s6"};
    tbl[11] = '{368, 256, 1'b1, 12'h888, "init_s7"};
    tbl[12] = '{33,  33,  1'b0, 12'h000, "blank_on_sprite"};
    tbl[13] = '{8,   8,   1'b1, GRIDEXP, "bg_grid_point"};

    // Reset state.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_rgb", rgb, 12'h000);
    check("reset_bounce", {11'b0, bounce}, 12'h000);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 14; i++)
      pix_exp(tbl[i].px, tbl[i].py, tbl[i].von, tbl[i].exp, tbl[i].nm);
    pix_exp(0, 0, 1'b1, GRIDEXP, "bg_origin");

    // First move at speed 2.
    frame(2, 1'b0);
    pix_exp(34, 34, 1'b1, 12'hF00, "move_s0");
    pix_exp(34, 33, 1'b1, 12'h000, "move_s0_above");
    pix_exp(78, 66, 1'b1, 12'h0F0, "move_s1");
    pix_exp(81, 69, 1'b1, 12'h0F0, "move_s1_br");
    pix_exp(77, 66, 1'b1, 12'h000, "move_s1_left");

    // Pause holds everything across several vsync rises.
    for (int i = 0; i < 3; i++) frame(3, 1'b1);
    pix_exp(34, 34, 1'b1, 12'hF00, "pause_s0");
    pix_exp(78, 66, 1'b1, 12'h0F0, "pause_s1");
    probe_all(1'b0);

    // Constant speed 4: sprite 0 reaches the right wall, others hit walls too.
    for (int f = 0; f < 170; f++) begin
      frame(4, 1'b0);
      probe_all(1'b0);
    end

    // speed 0 never moves nor bounces.
    frame(0, 1'b0);
    probe_all(1'b0);

    // Long run with random speed, occasional pause, jittered probes.
    for (int f = 0; f < 2000; f++) begin
      frame(int'($urandom_range(7, 0)), $urandom_range(7, 0) == 0);
      probe_all(1'b1);
    end

    // Mid-line reset while rgb shows a sprite.
    pix(mx[0], my[0], 1'b1, "pre_reset_pix");
    tick_edge();
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rgb", rgb, 12'h000);
    check("midreset_bounce", {11'b0, bounce}, 12'h000);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++)
      pix_exp(tbl[i].px, tbl[i].py, tbl[i].von, tbl[i].exp, tbl[i].nm);
    tick_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
